// File: rtl/bridge_req_host.sv
// Host-facing command window for core-to-host bridge requests: posts one arbitrated
// request as a status word plus eight params and tracks the host "ok"/"do" writes.
// Optional watchdog: define BRIDGE_REQ_HOST_TIMEOUT_EN to enable the request timeout.
module bridge_req_host #(
  parameter logic [31:0] BASE_ADDR      = 32'hF800_1000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd74_250_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  bridge_addr,
  input  logic         bridge_rd,
  output logic [31:0]  bridge_rd_data,
  input  logic         bridge_wr,
  input  logic [31:0]  bridge_wr_data,
  input  logic         req_valid,
  input  logic [15:0]  req_word,
  input  logic [255:0] req_param,
  output logic         req_ack,
  output logic         req_done,
  output logic [15:0]  req_result
);

  typedef enum logic [2:0] {
    IDLE,
    POST,
    WAIT_ACK,
    WAIT_DONE,
    DONE
  } state_t;

  localparam logic [15:0] MAGIC_CM = 16'h636D;
  localparam logic [15:0] MAGIC_OK = 16'h6F6B;
  localparam logic [15:0] MAGIC_DO = 16'h646F;

  state_t      state_reg, state_next;
  logic [15:0] word_reg;
  logic [31:0] param_reg [8];
  logic [31:0] status_reg, status_next;
  logic [31:0] rd_data_reg, rd_data_next;
  logic        ack_reg, ack_next;
  logic        done_reg, done_next;
  logic [15:0] result_reg, result_next;
  logic        timeout_hit;

  logic [31:0] offset;
  logic        status_wr;
  logic        is_ok;
  logic        is_do;
  logic        in_param_area;

  // Decoding on the offset from BASE_ADDR keeps the window relocatable.
  assign offset        = bridge_addr - BASE_ADDR;
  assign status_wr     = bridge_wr && (offset == 32'd0);
  assign is_ok         = status_wr && (bridge_wr_data[31:16] == MAGIC_OK);
  assign is_do         = status_wr && (bridge_wr_data[31:16] == MAGIC_DO);
  assign in_param_area = (offset[31:5] == 27'd1) && (offset[1:0] == 2'b00);

`ifdef BRIDGE_REQ_HOST_TIMEOUT_EN
  logic [31:0] timer_reg;

  // Cleared during POST so the first WAIT_ACK cycle counts as zero.
  always_ff @(posedge clk) begin
    if (reset || state_reg == POST) begin
      timer_reg <= '0;
    end else if (state_reg == WAIT_ACK || state_reg == WAIT_DONE) begin
      timer_reg <= timer_reg + 32'd1;
    end
  end

  assign timeout_hit = (state_reg == WAIT_ACK || state_reg == WAIT_DONE) &&
                       (timer_reg >= TIMEOUT_CYCLES - 32'd1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    status_next = status_reg;
    result_next = result_reg;
    ack_next    = 1'b0;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) state_next = POST;
      end
      POST: begin
        state_next  = WAIT_ACK;
        status_next = {MAGIC_CM, word_reg};
      end
      WAIT_ACK: begin
        // A "do" write beats expiry; expiry beats a late "ok" so the counter cannot overrun.
        if (is_do) begin
          state_next  = DONE;
          ack_next    = 1'b1;
          result_next = bridge_wr_data[15:0];
        end else if (timeout_hit) begin
          state_next  = DONE;
          result_next = 16'hFFFF;
        end else if (is_ok) begin
          state_next  = WAIT_DONE;
          ack_next    = 1'b1;
          status_next = {MAGIC_OK, 16'h0000};
        end
      end
      WAIT_DONE: begin
        if (is_do) begin
          state_next  = DONE;
          result_next = bridge_wr_data[15:0];
        end else if (timeout_hit) begin
          state_next  = DONE;
          result_next = 16'hFFFF;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (state_next == DONE) begin
      done_next   = 1'b1;
      status_next = '0;
    end
  end

  // Reads sample status_reg before this cycle's write lands, giving pre-write data.
  always_comb begin
    rd_data_next = rd_data_reg;
    if (bridge_rd) begin
      if (offset == 32'd0) begin
        rd_data_next = status_reg;
      end else if (in_param_area) begin
        rd_data_next = param_reg[offset[4:2]];
      end else begin
        rd_data_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      status_reg  <= '0;
      rd_data_reg <= '0;
      ack_reg     <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
      word_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      status_reg  <= status_next;
      rd_data_reg <= rd_data_next;
      ack_reg     <= ack_next;
      done_reg    <= done_next;
      result_reg  <= result_next;
      if (state_reg == IDLE && req_valid) word_reg <= req_word;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (reset) begin
        param_reg[i] <= '0;
      end else if (state_reg == IDLE && req_valid) begin
        param_reg[i] <= req_param[32*i +: 32];
      end
    end
  end

  assign bridge_rd_data = rd_data_reg;
  assign req_ack        = ack_reg;
  assign req_done       = done_reg;
  assign req_result     = result_reg;

endmodule

// File: tb/tb_bridge_req_host.sv
// Directed bench for bridge_req_host: read expectations go through a scoreboard queue,
// pulse counts come from an edge monitor.
module tb_bridge_req_host;

  localparam logic [31:0] BASE = 32'hF800_1000;

  logic         clk;
  logic         reset;
  logic [31:0]  bridge_addr;
  logic         bridge_rd;
  logic [31:0]  bridge_rd_data;
  logic         bridge_wr;
  logic [31:0]  bridge_wr_data;
  logic         req_valid;
  logic [15:0]  req_word;
  logic [255:0] req_param;
  logic         req_ack;
  logic         req_done;
  logic [15:0]  req_result;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_count  = 0;
  int done_count = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  bridge_req_host #(
    .BASE_ADDR(BASE),
    .TIMEOUT_CYCLES(32'd16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bridge_addr(bridge_addr),
    .bridge_rd(bridge_rd),
    .bridge_rd_data(bridge_rd_data),
    .bridge_wr(bridge_wr),
    .bridge_wr_data(bridge_wr_data),
    .req_valid(req_valid),
    .req_word(req_word),
    .req_param(req_param),
    .req_ack(req_ack),
    .req_done(req_done),
    .req_result(req_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses are counted on the edge that ends the cycle they were high in.
  always @(posedge clk) begin
    if (req_ack === 1'b1) ack_count++;
    if (req_done === 1'b1) done_count++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", bridge_rd_data, 32'hxxxx_xxxx);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, bridge_rd_data, e);
    end
  endtask

  task automatic host_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bridge_addr = addr;
    bridge_rd   = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    bridge_rd = 1'b0;
    pop_check();
  endtask

  task automatic host_write(input logic [31:0] addr, input logic [31:0] data);
    bridge_addr    = addr;
    bridge_wr_data = data;
    bridge_wr      = 1'b1;
    tick();
    bridge_wr = 1'b0;
  endtask

  function automatic logic [31:0] param_of(input logic [7:0] salt, input int n, input logic [31:0] p0);
    return (n == 0) ? p0 : {16'hA5A0, salt, 8'(n)};
  endfunction

  task automatic load_req(input logic [15:0] w, input logic [31:0] p0, input logic [7:0] salt);
    req_word = w;
    for (int n = 0; n < 8; n++) req_param[32*n +: 32] = param_of(salt, n, p0);
    req_valid = 1'b1;
  endtask

  initial begin
    int acks_before;
    int dones_before;
    int waited;

    reset = 1'b1;
    bridge_addr = '0;
    bridge_rd = 1'b0;
    bridge_wr = 1'b0;
    bridge_wr_data = '0;
    req_valid = 1'b0;
    req_word = '0;
    req_param = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_ack", {31'd0, req_ack}, 32'd0);
    check("rst_done", {31'd0, req_done}, 32'd0);
    check("rst_result", {16'd0, req_result}, 32'd0);
    check("rst_rd_data", bridge_rd_data, 32'd0);
    host_read(BASE, 32'd0, "rst_status");
    host_read(BASE + 32'h20, 32'd0, "rst_param0");

    // Basic flow: valid -> POST -> WAIT_ACK, status visible only after the second edge
    load_req(16'h0140, 32'h0000_0003, 8'h11);
    tick();
    host_read(BASE, 32'd0, "post_status_not_yet");
    host_read(BASE, 32'h636D_0140, "status_cm");
    host_read(BASE + 32'h20, 32'h0000_0003, "param0");
    host_read(BASE + 32'h3C, param_of(8'h11, 7, 32'h3), "param7");
    host_read(BASE + 32'h21, 32'd0, "unaligned_zero");
    host_read(BASE + 32'h40, 32'd0, "past_params_zero");
    host_read(BASE + 32'h04, 32'd0, "gap_zero");

    // Param stability: inputs change after POST, param area write ignored
    req_word = 16'hFFFF;
    req_param = {8{32'h5555_AAAA}};
    host_write(BASE + 32'h24, 32'hDEAD_BEEF);
    host_read(BASE + 32'h24, param_of(8'h11, 1, 32'h3), "param1_stable");
    host_read(BASE, 32'h636D_0140, "status_stable");

    // Bad magic in WAIT_ACK
    host_write(BASE, 32'h1234_5678);
    check("bad_magic_ack", {31'd0, req_ack}, 32'd0);
    host_read(BASE, 32'h636D_0140, "bad_magic_status");

    // Host "ok": ack the cycle after, one cycle wide
    host_write(BASE, 32'h6F6B_0000);
    check("ok_ack_high", {31'd0, req_ack}, 32'd1);
    check("ok_done_low", {31'd0, req_done}, 32'd0);
    tick();
    check("ok_ack_low", {31'd0, req_ack}, 32'd0);
    host_read(BASE, 32'h6F6B_0000, "status_ok");

    // Host "do" with a simultaneous read of status: read returns pre-write value
    bridge_addr = BASE;
    bridge_wr_data = 32'h646F_0000;
    bridge_wr = 1'b1;
    bridge_rd = 1'b1;
    exp_q.push_back(32'h6F6B_0000);
    tag_q.push_back("rd_wr_prewrite");
    tick();
    bridge_wr = 1'b0;
    bridge_rd = 1'b0;
    pop_check();
    check("do_done_high", {31'd0, req_done}, 32'd1);
    check("do_result", {16'd0, req_result}, 32'd0);
    check("do_ack_low", {31'd0, req_ack}, 32'd0);
    req_valid = 1'b0;
    tick();
    check("do_done_low", {31'd0, req_done}, 32'd0);
    host_read(BASE, 32'd0, "status_cleared");
    check("basic_ack_count", 32'(ack_count), 32'd1);
    check("basic_done_count", 32'(done_count), 32'd1);

    // "do" while IDLE is ignored
    host_write(BASE, 32'h646F_0000);
    tick();
    check("idle_do_done", {31'd0, req_done}, 32'd0);
    host_read(BASE, 32'd0, "idle_status");
    check("idle_done_count", 32'(done_count), 32'd1);
    check("idle_ack_count", 32'(ack_count), 32'd1);

    // Skip ack: "do" straight from WAIT_ACK
    load_req(16'h0200, 32'h0000_0077, 8'h22);
    tick();
    tick();
    host_read(BASE, 32'h636D_0200, "skip_status_cm");
    host_write(BASE, 32'h646F_0002);
    check("skip_ack", {31'd0, req_ack}, 32'd1);
    check("skip_done", {31'd0, req_done}, 32'd1);
    check("skip_result", {16'd0, req_result}, 32'd2);
    req_valid = 1'b0;
    tick();
    check("skip_ack_low", {31'd0, req_ack}, 32'd0);
    check("skip_done_low", {31'd0, req_done}, 32'd0);
    check("skip_result_held", {16'd0, req_result}, 32'd2);
    check("skip_ack_count", 32'(ack_count), 32'd2);
    check("skip_done_count", 32'(done_count), 32'd2);

    // Reset in WAIT_DONE drops the request silently
    load_req(16'h0400, 32'h0000_0009, 8'h33);
    tick();
    tick();
    host_write(BASE, 32'h6F6B_0000);
    check("mid_ack", {31'd0, req_ack}, 32'd1);
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dones_before = done_count;
    check("mid_rst_ack", {31'd0, req_ack}, 32'd0);
    check("mid_rst_done", {31'd0, req_done}, 32'd0);
    check("mid_rst_result", {16'd0, req_result}, 32'd0);
    check("mid_rst_rd_data", bridge_rd_data, 32'd0);
    host_read(BASE, 32'd0, "mid_rst_status");
    host_read(BASE + 32'h20, 32'd0, "mid_rst_param0");
    host_write(BASE, 32'h646F_0005);
    repeat (3) tick();
    check("mid_rst_no_done", 32'(done_count), 32'(dones_before));

`ifdef BRIDGE_REQ_HOST_TIMEOUT_EN
    // Timeout: done 16 cycles after WAIT_ACK entry, no ack
    acks_before = ack_count;
    load_req(16'h0500, 32'h0000_0001, 8'h44);
    tick();
    tick();
    waited = 0;
    while (waited < 40 && req_done !== 1'b1) begin
      tick();
      waited++;
    end
    check("timeout_latency", 32'(waited), 32'd16);
    check("timeout_result", {16'd0, req_result}, 32'h0000_FFFF);
    check("timeout_ack_low", {31'd0, req_ack}, 32'd0);
    req_valid = 1'b0;
    tick();
    tick();
    check("timeout_no_ack", 32'(ack_count), 32'(acks_before));
    check("timeout_done_count", 32'(done_count), 32'(dones_before + 1));
    host_read(BASE, 32'd0, "timeout_status");
`else
    // Without the watchdog the request waits indefinitely
    acks_before = ack_count;
    load_req(16'h0500, 32'h0000_0001, 8'h44);
    tick();
    tick();
    waited = 0;
    while (waited < 40 && req_done !== 1'b1) begin
      tick();
      waited++;
    end
    check("no_timeout_wait", 32'(waited), 32'd40);
    check("no_timeout_done_count", 32'(done_count), 32'(dones_before));
    check("no_timeout_ack_count", 32'(ack_count), 32'(acks_before));
    host_read(BASE, 32'h636D_0500, "no_timeout_status");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
